rgmii_inband_status_mon: RTL and testbench
==========================================

Name: rgmii_inband_status_mon

Overview:
- Sits between the RGMII receive pins of one Ethernet port and the TSE MAC status connection inputs (set_10, set_1000) of nios_system. One instance per port.
- Decodes the RGMII in-band link/speed/duplex status that the PHY drives on RXD while RX_CTL is low during inter-frame.
- Debounces the decoded status and drives the MAC speed-select inputs plus link indications.
- Re-registers RXD/RX_CTL towards the MAC with fixed one-cycle latency.

Parameters:
- STABLE_CNT, 8: consecutive identical valid status samples required before the status is accepted (1..255).
- LOSS_CNT, 1024: consecutive inter-frame samples reporting link down before the link is dropped (1..65535).

Ports:
- clk_clk  in  1  RX clock domain (PHY rx clock); all logic on rising edge.
- reset_reset_n  in  1  async active-low reset.
- rgmii_rxd_in  in  4  rising-edge RXD nibble from the DDR input register.
- rgmii_rx_ctl_in  in  1  rising-edge RX_CTL (RX_DV).
- rgmii_rxd_out  out  4  rgmii_rxd_in delayed 1 cycle, to the MAC rgmii_in.
- rgmii_rx_ctl_out  out  1  rgmii_rx_ctl_in delayed 1 cycle, to the MAC rx_control.
- set_10  out  1  to the MAC set_10.
- set_1000  out  1  to the MAC set_1000.
- link_up  out  1  qualified link state.
- full_duplex  out  1  qualified duplex.
- status_change  out  1  one-cycle pulse when any qualified output changes.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream): all outputs 0, state LINK_DOWN, counters 0.
- Pass-through: rgmii_rxd_out and rgmii_rx_ctl_out are registered copies with latency exactly 1. No gating in any state.
- Sample valid when rgmii_rx_ctl_in==0. Decode:
  - rxd[0] = link.
  - rxd[2:1] = speed: 00 = 10M, 01 = 100M, 10 = 1000M, 11 = invalid.
  - rxd[3] = duplex.
- Samples with rx_ctl==1 (frame) are ignored. They do not reset any counter, and all counters hold.
- Candidate register {link,speed,duplex} plus qual counter (8 bit):
  - A valid sample equal to the candidate increments qual, saturating at STABLE_CNT.
  - A differing sample loads the candidate and sets qual=1.
  - Speed 11 with link=1 sets qual=0 and leaves the candidate unchanged.
- States:
  - LINK_DOWN: when qual reaches STABLE_CNT with candidate link=1, load the qualified regs and go to LINK_UP. link_up=1 on the cycle after the STABLE_CNT-th sample.
  - LINK_UP:
    - A qualified candidate with link=1 and a different speed or duplex updates the outputs in place and pulses status_change.
    - A valid link=0 sample increments the loss counter (16 bit); any link=1 sample clears it.
    - When the loss counter reaches LOSS_CNT, go to LINK_DOWN, clear all qualified outputs, and pulse status_change.
- Output encoding: set_1000 = (speed==10) & link_up; set_10 = (speed==00) & link_up. 100M is both 0. Both are 0 in LINK_DOWN.
- status_change is a single cycle, asserted on the same edge the qualified outputs change. It never asserts twice for one transition.
- Simultaneous loss-threshold and requalification in the same cycle: loss wins, go to LINK_DOWN.
- Reset mid-qualification discards the candidate; qualification restarts from 0.

Optional Feature:
- Macro RGMII_STATUS_CHANGE_CNT_EN.
- When defined: adds output status_change_cnt, 16 bit.
  - Counts status_change pulses, saturates at 0xFFFF.
  - Cleared by reset and by new input cnt_clr (1 bit, synchronous).
  - cnt_clr coincident with a pulse: the count becomes 0.
- When undefined: neither port exists and no counter logic is generated.

Test Plan:
- Reset, then idle samples rx_ctl=0, rxd=4'b1101 (link, 1000M, FD) ×8 → link_up=1, set_1000=1, set_10=0, full_duplex=1 on cycle after 8th sample; status_change one pulse.
- From 1000M-FD link, rxd=4'b0011 ×7 then rx_ctl=1 frame ×100 then 4'b0011 ×1 → outputs stay unchanged until the 8th valid sample. Then set_1000=0, set_10=0 (100M), full_duplex=0, one status_change pulse.
- LINK_UP, LOSS_CNT=1024: rxd link=0 ×1023, one link=1 sample, link=0 ×1023 → link_up stays 1. Continue link=0 ×1 more after a 1024 run → link_up=0, set_*=0, pulse.
- rxd=4'b0111 (speed 11) interleaved every 4th sample with 4'b0001 → never qualifies; link_up remains 0.
- Random rxd/rx_ctl for 1000 cycles → rgmii_*_out equal inputs delayed exactly 1 cycle. Assert reset_reset_n low mid-stream → all outputs 0 immediately (async).
- With RGMII_STATUS_CHANGE_CNT_EN: 3 link up/down transitions → cnt=6; cnt_clr coincident with a 7th pulse → cnt=0.

Source files
------------

// File: rtl/rgmii_inband_status_mon_if.sv
// RGMII receive-side bundle: pin-side inputs and the re-registered copy towards the MAC.
interface rgmii_inband_status_mon_if;
  logic [3:0] rgmii_rxd_in;
  logic       rgmii_rx_ctl_in;
  logic [3:0] rgmii_rxd_out;
  logic       rgmii_rx_ctl_out;

  modport master (
    output rgmii_rxd_in, rgmii_rx_ctl_in,
    input  rgmii_rxd_out, rgmii_rx_ctl_out
  );

  modport slave (
    input  rgmii_rxd_in, rgmii_rx_ctl_in,
    output rgmii_rxd_out, rgmii_rx_ctl_out
  );
endinterface

// File: rtl/rgmii_inband_status_mon.sv
// RGMII in-band status decoder/debouncer driving TSE MAC set_10/set_1000 and link indications.
// Optional status_change_cnt/cnt_clr ports enabled by macro RGMII_STATUS_CHANGE_CNT_EN.
module rgmii_inband_status_mon #(
  parameter int unsigned STABLE_CNT = 8,
  parameter int unsigned LOSS_CNT   = 1024
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  rgmii_inband_status_mon_if.slave rgmii,
  output logic                   set_10,
  output logic                   set_1000,
  output logic                   link_up,
  output logic                   full_duplex,
  output logic                   status_change
`ifdef RGMII_STATUS_CHANGE_CNT_EN
  ,
  input  logic                   cnt_clr,
  output logic [15:0]            status_change_cnt
`endif
);

  localparam logic [7:0]  STABLE_V = 8'(STABLE_CNT);
  localparam logic [15:0] LOSS_V   = 16'(LOSS_CNT);

  typedef enum logic {LINK_DOWN, LINK_UP} state_t;

  state_t      state_q;
  logic [3:0]  cand_q, cand_d;
  logic [7:0]  qual_q, qual_d;
  logic [15:0] loss_q, loss_d;
  logic [1:0]  speed_q;
  logic        link_up_q, set_10_q, set_1000_q, full_duplex_q, status_change_q;

  logic sample_valid, s_link, s_bad, qualified, loss_hit, differs;

  assign sample_valid = ~rgmii.rgmii_rx_ctl_in;
  assign s_link       = rgmii.rgmii_rxd_in[0];
  assign s_bad        = s_link && (rgmii.rgmii_rxd_in[2:1] == 2'b11);

  // Candidate is kept in RXD bit order {duplex, speed, link}
  always_comb begin
    cand_d = cand_q;
    qual_d = qual_q;
    loss_d = loss_q;
    if (sample_valid) begin
      if (s_bad) begin
        qual_d = '0;
      end else if (rgmii.rgmii_rxd_in == cand_q) begin
        qual_d = (qual_q >= STABLE_V) ? STABLE_V : qual_q + 8'd1;
      end else begin
        cand_d = rgmii.rgmii_rxd_in;
        qual_d = 8'd1;
      end
      if (state_q == LINK_UP) begin
        if (s_link)              loss_d = '0;
        else if (loss_q < LOSS_V) loss_d = loss_q + 16'd1;
      end
    end
  end

  assign qualified = (qual_d == STABLE_V) && cand_d[0];
  assign loss_hit  = (state_q == LINK_UP) && (loss_d == LOSS_V);
  assign differs   = (cand_d[2:1] != speed_q) || (cand_d[3] != full_duplex_q);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q                <= LINK_DOWN;
      cand_q                 <= '0;
      qual_q                 <= '0;
      loss_q                 <= '0;
      speed_q                <= '0;
      link_up_q              <= 1'b0;
      set_10_q               <= 1'b0;
      set_1000_q             <= 1'b0;
      full_duplex_q          <= 1'b0;
      status_change_q        <= 1'b0;
      rgmii.rgmii_rxd_out    <= '0;
      rgmii.rgmii_rx_ctl_out <= 1'b0;
    end else begin
      rgmii.rgmii_rxd_out    <= rgmii.rgmii_rxd_in;
      rgmii.rgmii_rx_ctl_out <= rgmii.rgmii_rx_ctl_in;
      cand_q                 <= cand_d;
      qual_q                 <= qual_d;
      loss_q                 <= loss_d;
      status_change_q        <= 1'b0;
      case (state_q)
        LINK_DOWN: begin
          if (qualified) begin
            state_q         <= LINK_UP;
            link_up_q       <= 1'b1;
            speed_q         <= cand_d[2:1];
            set_1000_q      <= (cand_d[2:1] == 2'b10);
            set_10_q        <= (cand_d[2:1] == 2'b00);
            full_duplex_q   <= cand_d[3];
            status_change_q <= 1'b1;
          end
        end
        LINK_UP: begin
          // Loss takes priority over any simultaneous requalification
          if (loss_hit) begin
            state_q         <= LINK_DOWN;
            loss_q          <= '0;
            link_up_q       <= 1'b0;
            speed_q         <= '0;
            set_1000_q      <= 1'b0;
            set_10_q        <= 1'b0;
            full_duplex_q   <= 1'b0;
            status_change_q <= 1'b1;
          end else if (qualified && differs) begin
            speed_q         <= cand_d[2:1];
            set_1000_q      <= (cand_d[2:1] == 2'b10);
            set_10_q        <= (cand_d[2:1] == 2'b00);
            full_duplex_q   <= cand_d[3];
            status_change_q <= 1'b1;
          end
        end
        default: state_q <= LINK_DOWN;
      endcase
    end
  end

  assign link_up       = link_up_q;
  assign set_10        = set_10_q;
  assign set_1000      = set_1000_q;
  assign full_duplex   = full_duplex_q;
  assign status_change = status_change_q;

`ifdef RGMII_STATUS_CHANGE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                         cnt_q <= '0;
    else if (cnt_clr)                           cnt_q <= '0;
    else if (status_change_q && (cnt_q != '1))  cnt_q <= cnt_q + 16'd1;
  end

  assign status_change_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rgmii_inband_status_mon.sv
// Self-checking bench for rgmii_inband_status_mon against a sample-history reference model.
module tb_rgmii_inband_status_mon;
  localparam int unsigned STABLE = 8;
  localparam int unsigned LOSS   = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgmii_inband_status_mon_if bus ();
  logic set_10, set_1000, link_up, full_duplex, status_change;
`ifdef RGMII_STATUS_CHANGE_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [15:0] status_change_cnt;
`endif

  rgmii_inband_status_mon #(.STABLE_CNT(STABLE), .LOSS_CNT(LOSS)) u_dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .rgmii         (bus.slave),
    .set_10        (set_10),
    .set_1000      (set_1000),
    .link_up       (link_up),
    .full_duplex   (full_duplex),
    .status_change (status_change)
`ifdef RGMII_STATUS_CHANGE_CNT_EN
    ,
    .cnt_clr           (cnt_clr),
    .status_change_cnt (status_change_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  // Reference model: history of recent valid samples and a run of link-down samples
  logic [3:0]  hist[$];
  int          run0;
  bit          m_up, m_dup, m_pulse;
  logic [1:0]  m_spd;
  logic [3:0]  prev_rxd;
  bit          prev_ctl;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    run0 = 0; m_up = 0; m_dup = 0; m_spd = 2'b00; m_pulse = 0;
    prev_rxd = 4'h0; prev_ctl = 0; m_cnt = 16'h0;
  endtask

  task automatic model_step(input logic [3:0] d, input logic c, input bit clr);
    bit qual;
    bit was_pulse;
    was_pulse = m_pulse;
    m_pulse = 0;
    if (clr) m_cnt = 16'h0;
    else if (was_pulse && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (!c) begin
      hist.push_back(d);
      if (hist.size() > STABLE) void'(hist.pop_front());
      run0 = d[0] ? 0 : run0 + 1;
      qual = (hist.size() == STABLE);
      foreach (hist[i]) if (hist[i] !== d || (hist[i][0] && hist[i][2:1] == 2'b11)) qual = 0;
      if (m_up && !d[0] && run0 >= int'(LOSS)) begin
        m_up = 0; m_spd = 2'b00; m_dup = 0; m_pulse = 1;
      end else if (qual && d[0] && (!m_up || d[2:1] != m_spd || d[3] != m_dup)) begin
        m_up = 1; m_spd = d[2:1]; m_dup = d[3]; m_pulse = 1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rxd_out", 16'(bus.rgmii_rxd_out), 16'(prev_rxd));
    chk("ctl_out", 16'(bus.rgmii_rx_ctl_out), 16'(prev_ctl));
    chk("link_up", 16'(link_up), 16'(m_up));
    chk("set_1000", 16'(set_1000), 16'(m_up && m_spd == 2'b10));
    chk("set_10", 16'(set_10), 16'(m_up && m_spd == 2'b00));
    chk("full_duplex", 16'(full_duplex), 16'(m_up && m_dup));
    chk("status_change", 16'(status_change), 16'(m_pulse));
`ifdef RGMII_STATUS_CHANGE_CNT_EN
    chk("status_change_cnt", status_change_cnt, m_cnt);
`endif
    if (status_change === 1'b1) pulses++;
  endtask

  task automatic step(input logic [3:0] d, input logic c);
    bit clr;
    clr = 0;
`ifdef RGMII_STATUS_CHANGE_CNT_EN
    clr = cnt_clr;
`endif
    bus.rgmii_rxd_in    = d;
    bus.rgmii_rx_ctl_in = c;
    #1;
    chk("rxd_hold", 16'(bus.rgmii_rxd_out), 16'(prev_rxd));
    chk("ctl_hold", 16'(bus.rgmii_rx_ctl_out), 16'(prev_ctl));
    @(posedge clk);
    #1;
    model_step(d, c, clr);
    prev_rxd = d;
    prev_ctl = c;
    check_outputs();
  endtask

  initial begin
    logic [3:0] val;
    int burst;
    bus.rgmii_rxd_in    = 4'h0;
    bus.rgmii_rx_ctl_in = 1'b0;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1'b1;

    // Qualify 1000M full duplex
    pulses = 0;
    repeat (STABLE - 1) step(4'b1101, 1'b0);
    chk("t1_not_yet_up", 16'(link_up), 16'd0);
    step(4'b1101, 1'b0);
    chk("t1_link_up", 16'(link_up), 16'd1);
    chk("t1_set_1000", 16'(set_1000), 16'd1);
    chk("t1_set_10", 16'(set_10), 16'd0);
    chk("t1_fd", 16'(full_duplex), 16'd1);
    step(4'b1101, 1'b0);
    chk("t1_pulses", 16'(pulses), 16'd1);

    // Speed change to 100M half duplex across an intervening frame
    pulses = 0;
    repeat (STABLE - 1) step(4'b0011, 1'b0);
    repeat (100) step(4'($urandom), 1'b1);
    chk("t2_unchanged", 16'(set_1000), 16'd1);
    step(4'b0011, 1'b0);
    chk("t2_set_1000", 16'(set_1000), 16'd0);
    chk("t2_set_10", 16'(set_10), 16'd0);
    chk("t2_fd", 16'(full_duplex), 16'd0);
    chk("t2_link", 16'(link_up), 16'd1);
    step(4'b0011, 1'b0);
    chk("t2_pulses", 16'(pulses), 16'd1);

    // Loss counter boundary
    pulses = 0;
    repeat (LOSS - 1) step(4'b0000, 1'b0);
    step(4'b0011, 1'b0);
    repeat (LOSS - 1) step(4'b0000, 1'b0);
    chk("t3_still_up", 16'(link_up), 16'd1);
    chk("t3_no_pulse", 16'(pulses), 16'd0);
    step(4'b0000, 1'b0);
    chk("t3_link_down", 16'(link_up), 16'd0);
    chk("t3_pulse", 16'(status_change), 16'd1);
    chk("t3_set_10", 16'(set_10), 16'd0);

    // Invalid speed interleaved never qualifies
    repeat (10) begin
      repeat (3) step(4'b0001, 1'b0);
      step(4'b0111, 1'b0);
    end
    chk("t4_down", 16'(link_up), 16'd0);

    // Random bursts with an asynchronous reset mid-stream
    burst = 0;
    val = 4'h0;
    for (int i = 0; i < 1000; i++) begin
      if (burst == 0) begin
        case ($urandom_range(0, 6))
          0: val = 4'b1101;
          1: val = 4'b0011;
          2: val = 4'b1001;
          3: val = 4'b0101;
          4: val = 4'b0111;
          5: val = 4'b0000;
          default: val = 4'($urandom);
        endcase
        burst = int'($urandom_range(1, 12));
      end
      burst--;
      step(val, 1'($urandom_range(0, 4) == 0));
      if (i == 500) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2 rst_n = 1'b1;
      end
    end

`ifdef RGMII_STATUS_CHANGE_CNT_EN
    #2 rst_n = 1'b0;
    #1 model_reset();
    #2 rst_n = 1'b1;
    repeat (3) begin
      repeat (STABLE) step(4'b1101, 1'b0);
      repeat (LOSS) step(4'b0000, 1'b0);
    end
    step(4'b0000, 1'b0);
    chk("cnt_six", status_change_cnt, 16'd6);
    repeat (STABLE) step(4'b1101, 1'b0);
    cnt_clr = 1'b1;
    step(4'b1101, 1'b0);
    cnt_clr = 1'b0;
    step(4'b1101, 1'b0);
    chk("cnt_cleared", status_change_cnt, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
